// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU control codes and state encoding for the sequential multiplier.
// The ALU itself lives in the parent; only its {zx,nx,zy,ny,f,no} pin codes are defined here.
package alu_mul_seq_pkg;

    localparam logic [5:0] ALU_ADD  = 6'b000010;
    localparam logic [5:0] ALU_ZERO = 6'b101010;
    localparam logic [5:0] ALU_X    = 6'b001100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 16x16 shift-and-add multiplier, MSB first, that borrows the shared Hack ALU
// for every addition (doubling acc+acc, then acc+a when the multiplier bit is set).
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter bit SKIP_ZERO_ADD = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid is never dropped before the transfer, and ready never depends on valid.
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        ovf,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctl,
    input  logic [15:0] alu_out,
    output logic [1:0]  dbgState
);

    state_t      state;
    state_t      stateNext;
    logic [15:0] acc;
    logic [15:0] aQ;
    logic [15:0] bQ;
    logic [3:0]  idx;
    logic        ovfQ;
    logic        bitSet;
    logic        carry;

    assign bitSet = bQ[idx];
    // Carry out of the 16-bit add, recovered from operand and result sign bits.
    assign carry  = (alu_x[15] & alu_y[15]) | ((alu_x[15] | alu_y[15]) & ~alu_out[15]);

    always_comb begin
        stateNext = state;
        alu_ctl   = ALU_ZERO;
        alu_x     = 16'h0000;
        alu_y     = 16'h0000;
        case (state)
            IDLE: begin
                if (in_valid) stateNext = DBL;
            end
            DBL: begin
                alu_ctl = ALU_ADD;
                alu_x   = acc;
                alu_y   = acc;
                if (bitSet || !SKIP_ZERO_ADD) stateNext = ADD;
                else if (idx == 4'd0)         stateNext = DONE;
                else                          stateNext = DBL;
            end
            ADD: begin
                alu_ctl   = ALU_ADD;
                alu_x     = acc;
                alu_y     = bitSet ? aQ : 16'h0000;
                stateNext = (idx == 4'd0) ? DONE : DBL;
            end
            DONE: begin
                if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= 16'h0000;
            aQ   <= 16'h0000;
            bQ   <= 16'h0000;
            idx  <= 4'd0;
            ovfQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aQ   <= a;
                        bQ   <= b;
                        acc  <= 16'h0000;
                        ovfQ <= 1'b0;
                        idx  <= 4'd15;
                    end
                end
                DBL: begin
                    acc  <= alu_out;
                    ovfQ <= ovfQ | acc[15];
                    // Skipped ADD: this doubling closes the bit, so step to the next one here.
                    if (stateNext == DBL) idx <= idx - 4'd1;
                end
                ADD: begin
                    acc  <= alu_out;
                    ovfQ <= ovfQ | carry;
                    if (idx != 4'd0) idx <= idx - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;
    assign ovf       = ovfQ;
    assign dbgState  = state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (ADD skipping on and off), each closed through a
// behavioural Hack ALU, checked against plain-arithmetic expectations for product, ovf, latency.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        drvValid;
    logic        drvReady;
    int          sel;

    logic        inValid0, inReady0, outValid0, outReady0, ovf0;
    logic        inValid1, inReady1, outValid1, outReady1, ovf1;
    logic [15:0] product0, aluX0, aluY0, aluOut0;
    logic [15:0] product1, aluX1, aluY1, aluOut1;
    logic [5:0]  aluCtl0, aluCtl1;
    logic [1:0]  dbgState0, dbgState1;

    logic        inReadyM, outValidM, ovfM;
    logic [15:0] productM;
    logic [1:0]  stateM;

    int checks;
    int failures;

    function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] ctl);
        logic [15:0] xx, yy, o;
        xx = ctl[5] ? 16'h0000 : x;
        if (ctl[4]) xx = ~xx;
        yy = ctl[3] ? 16'h0000 : y;
        if (ctl[2]) yy = ~yy;
        o = ctl[1] ? (xx + yy) : (xx & yy);
        if (ctl[0]) o = ~o;
        return o;
    endfunction

    assign aluOut0 = hackAlu(aluX0, aluY0, aluCtl0);
    assign aluOut1 = hackAlu(aluX1, aluY1, aluCtl1);

    assign inValid0  = drvValid & (sel == 0);
    assign inValid1  = drvValid & (sel == 1);
    assign outReady0 = drvReady & (sel == 0);
    assign outReady1 = drvReady & (sel == 1);
    assign inReadyM  = (sel == 1) ? inReady1  : inReady0;
    assign outValidM = (sel == 1) ? outValid1 : outValid0;
    assign productM  = (sel == 1) ? product1  : product0;
    assign ovfM      = (sel == 1) ? ovf1      : ovf0;
    assign stateM    = (sel == 1) ? dbgState1 : dbgState0;

    alu_mul_seq #(.SKIP_ZERO_ADD(1'b0)) u_fixed (
        .clock(clock), .reset_n(reset_n),
        .in_valid(inValid0), .in_ready(inReady0), .a(a), .b(b),
        .out_valid(outValid0), .out_ready(outReady0), .product(product0), .ovf(ovf0),
        .alu_x(aluX0), .alu_y(aluY0), .alu_ctl(aluCtl0), .alu_out(aluOut0),
        .dbgState(dbgState0)
    );

    alu_mul_seq #(.SKIP_ZERO_ADD(1'b1)) u_skip (
        .clock(clock), .reset_n(reset_n),
        .in_valid(inValid1), .in_ready(inReady1), .a(a), .b(b),
        .out_valid(outValid1), .out_ready(outReady1), .product(product1), .ovf(ovf1),
        .alu_x(aluX1), .alu_y(aluY1), .alu_ctl(aluCtl1), .alu_out(aluOut1),
        .dbgState(dbgState1)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One full transaction on instance s; the DONE state is held for 'hold' cycles first.
    task automatic do_op(input int s, input logic [15:0] av, input logic [15:0] bv,
                         input int hold, input string tag);
        logic [31:0] full;
        logic [15:0] expP;
        logic        expOvf;
        int          expLat;
        int          lat;
        full   = 32'(av) * 32'(bv);
        expP   = full[15:0];
        expOvf = (full > 32'h0000_FFFF);
        expLat = (s == 1) ? 16 + $countones(bv) : 32;
        sel = s;
        @(negedge clock);
        checks++;
        if (inReadyM !== 1'b1)
            $display("FAIL %s in_ready_idle got=%b want=1", tag, inReadyM);
        a = av;
        b = bv;
        drvValid = 1'b1;
        @(posedge clock);
        #1 drvValid = 1'b0;
        checks++;
        if (inReadyM !== 1'b0) begin
            failures++;
            $display("FAIL %s in_ready_busy got=%b want=0", tag, inReadyM);
        end
        lat = 0;
        while (outValidM !== 1'b1 && lat < 100) begin
            @(posedge clock);
            #1 lat++;
        end
        checks++;
        if (lat != expLat) begin
            failures++;
            $display("FAIL %s latency a=%h b=%h got=%0d want=%0d", tag, av, bv, lat, expLat);
        end
        checks++;
        if (productM !== expP) begin
            failures++;
            $display("FAIL %s product a=%h b=%h got=%h want=%h", tag, av, bv, productM, expP);
        end
        checks++;
        if (ovfM !== expOvf) begin
            failures++;
            $display("FAIL %s ovf a=%h b=%h got=%b want=%b", tag, av, bv, ovfM, expOvf);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (outValidM !== 1'b1 || productM !== expP || ovfM !== expOvf || inReadyM !== 1'b0) begin
                failures++;
                $display("FAIL %s hold_stable cyc=%0d valid=%b prod=%h ovf=%b rdy=%b want 1/%h/%b/0",
                         tag, i, outValidM, productM, ovfM, inReadyM, expP, expOvf);
            end
        end
        @(negedge clock);
        drvReady = 1'b1;
        @(posedge clock);
        #1 drvReady = 1'b0;
        checks++;
        if (inReadyM !== 1'b1 || outValidM !== 1'b0 || stateM !== IDLE) begin
            failures++;
            $display("FAIL %s retire in_ready=%b out_valid=%b state=%0d want 1/0/%0d",
                     tag, inReadyM, outValidM, stateM, IDLE);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        drvValid = 1'b0;
        drvReady = 1'b0;
        a = 16'h0;
        b = 16'h0;
        sel = 1;
        #12;
        checks++;
        if (outValid0 !== 1'b0 || outValid1 !== 1'b0 || product0 !== 16'h0 || product1 !== 16'h0
            || ovf0 !== 1'b0 || ovf1 !== 1'b0 || dbgState0 !== IDLE || dbgState1 !== IDLE) begin
            failures++;
            $display("FAIL reset_state valid=%b%b prod=%h/%h ovf=%b%b st=%0d/%0d want 00/0/0/00/idle",
                     outValid0, outValid1, product0, product1, ovf0, ovf1, dbgState0, dbgState1);
        end
        checks++;
        if (aluCtl1 !== 6'b101010 || aluX1 !== 16'h0 || aluY1 !== 16'h0) begin
            failures++;
            $display("FAIL reset_alu ctl=%b x=%h y=%h want 101010/0/0", aluCtl1, aluX1, aluY1);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (inReady0 !== 1'b1 || inReady1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b%b want=11", inReady0, inReady1);
        end
    endtask

    task automatic test_directed();
        do_op(1, 16'd3, 16'd5, 0, "d3x5");
        do_op(1, 16'h1234, 16'h0000, 0, "b0_skip");
        do_op(0, 16'h1234, 16'h0000, 0, "b0_fixed");
        do_op(1, 16'hFFFF, 16'hFFFF, 0, "ffff_sq");
        do_op(1, 16'd2, 16'd3, 0, "sticky_clear");
        do_op(1, 16'h0100, 16'h0100, 0, "wrap_zero");
        do_op(1, 16'h00FF, 16'h0101, 0, "max_fit");
        do_op(0, 16'hFFFF, 16'hFFFF, 0, "ffff_fixed");
        do_op(0, 16'd3, 16'd5, 0, "d3x5_fixed");
    endtask

    task automatic test_backpressure();
        do_op(1, 16'h0123, 16'h0045, 5, "bp_skip");
        do_op(0, 16'h8001, 16'h0003, 5, "bp_fixed");
    endtask

    task automatic test_reset_mid();
        sel = 1;
        @(negedge clock);
        a = 16'h1234;
        b = 16'h0000;
        drvValid = 1'b1;
        @(posedge clock);
        #1 drvValid = 1'b0;
        repeat (6) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dbgState1 !== IDLE || outValid1 !== 1'b0 || product1 !== 16'h0 || ovf1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid state=%0d valid=%b prod=%h ovf=%b want idle/0/0/0",
                     dbgState1, outValid1, product1, ovf1);
        end
        @(negedge clock);
        reset_n = 1'b1;
        do_op(1, 16'd7, 16'd9, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        for (int n = 0; n < 30; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom);
                1:       rb = 16'($urandom_range(0, 255));
                2:       rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0001;
                default: begin
                    ra = 16'($urandom_range(0, 255));
                    rb = 16'($urandom_range(0, 255));
                end
            endcase
            do_op(n % 2, ra, rb, $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++)
            do_op(1, 16'(n * 1000 + 17), 16'(n * 33 + 1), 0, "b2b");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
